tff_bank: RTL
=============

Name: tff_bank

Overview:
Parametrised bank of T flip-flops. It generalises the fixed three-stage toggle chain with a single last-stage output to WIDTH stages, and adds two selectable modes: independent per-stage toggle, and a cascaded synchronous counter. It also adds parallel load, a terminal-count pulse and a saturating MSB-toggle counter. The block sits at top level as a reusable toggle/count primitive for lab designs and is driven directly by switch-style inputs.

Parameters:
WIDTH, 3, number of toggle stages (>=1)
RST_VAL, 0, value of q after reset (WIDTH bits)
CNT_W, 8, width of msb_toggles counter (>=1)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-low (0 = reset, sampled on rising clk)
en  input  1  toggle enable; 0 = hold state
mode  input  1  0 = independent toggle, 1 = cascaded counter
t  input  WIDTH  per-stage toggle requests
load  input  1  parallel load strobe
load_val  input  WIDTH  value loaded into q when load=1
q  output  WIDTH  stage outputs (registered)
q_msb  output  1  q[WIDTH-1], combinational copy of the register bit
tc  output  1  registered one-cycle terminal-count (wrap) pulse
msb_toggles  output  CNT_W  saturating count of toggle-caused q_msb changes

Behaviour:
- Priority at each rising edge: rst=0 > load=1 > en=1 > hold.
- Reset (rst=0): q=RST_VAL, tc=0, msb_toggles=0. Reset overrides load/en. Reset mid-count takes effect at the next edge, with no partial update.
- Load (rst=1, load=1): q<=load_val regardless of en/mode/t. tc<=0. msb_toggles unchanged, even if q_msb changes.
- Independent mode (mode=0, en=1, load=0): q[i]<=q[i]^t[i] for every i.
- Cascade mode (mode=1, en=1, load=0): stage i toggles iff t[k]=1 for all k<=i AND q[k]=1 for all k<i.
  - With t all ones this is a mod-2^WIDTH binary up-counter.
  - A zero in t[j] freezes stage j and all stages above it.
- en=0, load=0: q holds. tc<=0. msb_toggles holds.
- tc <= rst & ~load & en & mode & (&t) & (&q).
  - tc is high for exactly the one cycle in which q shows the wrapped value 0.
  - Never asserted in mode 0.
- msb_toggles increments by 1 on every edge where q[WIDTH-1] flips due to a toggle (either mode). It saturates at 2^CNT_W-1 and never wraps.
- Latency: q, tc and msb_toggles all reflect inputs sampled at edge N in the cycle after edge N. There is no combinational path from inputs to outputs.
- mode may change any cycle. The new mode applies from that edge, and no state is cleared.
- WIDTH=1: both modes are identical (q[0] toggles when t[0]=1). tc fires on each 1->0 transition in mode 1.
- Simultaneous load and wrap condition: load wins, tc=0.

Test Plan:
- WIDTH=3, rst=0 for 5 cycles then rst=1, mode=0, en=1, t=3'b101 -> q alternates 000,101,000,...; q_msb toggles every cycle; msb_toggles increments 1 per cycle; tc stays 0.
- Cascade: mode=1, t=3'b111, en=1 from q=0 -> q counts 0..7 then 0; tc=1 only in the cycle q=0 after 7; msb_toggles=2 after 8 edges, 4 after 16.
- Cascade with t=3'b011 from q=0 -> q cycles 0,1,2,3,0 in the low bits; q[2] stays 0; tc never asserts; msb_toggles stays 0.
- Load priority: q=7, mode=1, t=111, en=1, load=1, load_val=3'b110 -> next q=6, tc=0, msb_toggles unchanged; then load=0, en=0 -> q holds 6 for 3 cycles.
- Reset mid-operation: cascade counting, drive rst=0 when q=5 with load=1 -> next edge q=RST_VAL(0), tc=0, msb_toggles=0; rst=1 -> counting resumes 1,2,...
- Saturation: CNT_W=2, mode=0, t=3'b100, en=1 -> msb_toggles 0,1,2,3,3,3; q_msb keeps toggling.

Source files
------------

// File: rtl/tff_bank_if.sv
// rtl/tff_bank_if.sv - control/status bundle for the toggle flip-flop bank
interface tff_bank_if #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
);
    logic             en;
    logic             mode;
    logic [WIDTH-1:0] t;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             q_msb;
    logic             tc;
    logic [CNT_W-1:0] msb_toggles;

    modport master (
        output en, mode, t, load, load_val,
        input  q, q_msb, tc, msb_toggles
    );

    modport slave (
        input  en, mode, t, load, load_val,
        output q, q_msb, tc, msb_toggles
    );
endinterface

// File: rtl/tff_bank.sv
// rtl/tff_bank.sv - parametrised T flip-flop bank with independent/cascade modes
module tff_bank #(
    parameter int               WIDTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int               CNT_W   = 8
) (
    input  logic       clk,
    input  logic       rst,
    tff_bank_if.slave  bus
);
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] tog;
    logic             carry;
    logic             tc_q, tc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Cascade: a stage toggles only when every lower stage is requested and already set.
    always_comb begin
        tog   = '0;
        carry = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (bus.mode) begin
                carry  = carry & bus.t[i];
                tog[i] = carry;
                carry  = carry & q_q[i];
            end else begin
                tog[i] = bus.t[i];
            end
        end
    end

    always_comb begin
        q_d   = q_q;
        tc_d  = 1'b0;
        cnt_d = cnt_q;
        if (bus.load) begin
            q_d = bus.load_val;
        end else if (bus.en) begin
            q_d  = q_q ^ tog;
            tc_d = bus.mode & (&bus.t) & (&q_q);
            if (tog[WIDTH-1] && (cnt_q != '1)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_q   <= RST_VAL;
            tc_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            q_q   <= q_d;
            tc_q  <= tc_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.q           = q_q;
    assign bus.q_msb       = q_q[WIDTH-1];
    assign bus.tc          = tc_q;
    assign bus.msb_toggles = cnt_q;
endmodule
